// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared defaults, opcodes and ROB entry type for the crossbar return path
package xbar_pkg;

  localparam int XBAR_NUM_BANK  = 4;
  localparam int XBAR_ROB_DEPTH = 8;
  localparam int XBAR_DATA_W    = 128;
  localparam int XBAR_CH_ID_W   = 2;

  // Request opcodes seen on the crossbar request side.
  localparam logic [1:0] XBAR_OP_READ = 2'b00;

  // Bank select lives in request address bits [9:8].
  localparam int XBAR_BANK_SEL_HI = 9;
  localparam int XBAR_BANK_SEL_LO = 8;

  // Reference layout of one ROB entry at the default configuration.
  typedef struct packed {
    logic                                 alloc;
    logic                                 done;
    logic [$clog2(XBAR_NUM_BANK)-1:0]     bank_id;
    logic [XBAR_DATA_W-1:0]               data;
  } xbar_rob_entry_t;

endpackage

// File: rtl/xbar_rtn_demux.sv
// rtl/xbar_rtn_demux.sv - filters bank returns by channel/entry state and steers them to ROB entries
module xbar_rtn_demux
  import xbar_pkg::*;
#(
  parameter int NUM_BANK  = XBAR_NUM_BANK,
  parameter int ROB_DEPTH = XBAR_ROB_DEPTH,
  parameter int DATA_W    = XBAR_DATA_W,
  parameter int CH_ID_W   = XBAR_CH_ID_W,
  parameter int CH_ID     = 0,
  parameter int ROB_W     = $clog2(ROB_DEPTH),
  parameter int BANK_W    = $clog2(NUM_BANK)
) (
  input  logic [NUM_BANK-1:0]          bank_rtn_valid_i,
  input  logic [NUM_BANK*CH_ID_W-1:0]  bank_rtn_ch_id_i,
  input  logic [NUM_BANK*ROB_W-1:0]    bank_rtn_rob_num_i,
  input  logic [NUM_BANK*DATA_W-1:0]   bank_rtn_data_i,
  input  logic [ROB_DEPTH-1:0]         entry_alloc_i,
  input  logic [ROB_DEPTH-1:0]         entry_done_i,
  input  logic [ROB_DEPTH*BANK_W-1:0]  entry_bank_id_i,
  output logic [ROB_DEPTH-1:0]         wr_en_o,
  output logic [ROB_DEPTH*DATA_W-1:0]  wr_data_o
);

  logic [ROB_W-1:0] sel_num;

  // A return lands only on an allocated, not-yet-done entry that was sent to this bank;
  // distinct banks always target distinct entries, so per-entry writes never collide.
  always_comb begin
    wr_en_o   = '0;
    wr_data_o = '0;
    sel_num   = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      sel_num = bank_rtn_rob_num_i[b*ROB_W +: ROB_W];
      if (bank_rtn_valid_i[b] &&
          (bank_rtn_ch_id_i[b*CH_ID_W +: CH_ID_W] == CH_ID_W'(CH_ID)) &&
          entry_alloc_i[sel_num] && !entry_done_i[sel_num] &&
          (entry_bank_id_i[sel_num*BANK_W +: BANK_W] == BANK_W'(b))) begin
        wr_en_o[sel_num]                    = 1'b1;
        wr_data_o[sel_num*DATA_W +: DATA_W] = bank_rtn_data_i[b*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/xbar_ch_rob.sv
// rtl/xbar_ch_rob.sv - per-channel reorder buffer, in-order return; XBAR_ROB_BYPASS_EN enables 0-cycle head bypass
module xbar_ch_rob
  import xbar_pkg::*;
#(
  parameter int NUM_BANK  = XBAR_NUM_BANK,
  parameter int ROB_DEPTH = XBAR_ROB_DEPTH,
  parameter int DATA_W    = XBAR_DATA_W,
  parameter int CH_ID_W   = XBAR_CH_ID_W,
  parameter int CH_ID     = 0,
  localparam int ROB_W    = $clog2(ROB_DEPTH),
  localparam int BANK_W   = $clog2(NUM_BANK)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_kickoff_i,
  input  logic [BANK_W-1:0]            req_bank_id_i,
  output logic [ROB_W-1:0]             rob_alloc_num_o,
  output logic                         rob_full_o,
  input  logic [NUM_BANK-1:0]          bank_rtn_valid_i,
  output logic [NUM_BANK-1:0]          bank_rtn_allowIn_o,
  input  logic [NUM_BANK*CH_ID_W-1:0]  bank_rtn_ch_id_i,
  input  logic [NUM_BANK*ROB_W-1:0]    bank_rtn_rob_num_i,
  input  logic [NUM_BANK*DATA_W-1:0]   bank_rtn_data_i,
  output logic                         ch_rtn_data_valid_o,
  input  logic                         ch_rtn_data_ready_i,
  output logic [DATA_W-1:0]            ch_rtn_data_o
);

  logic [ROB_W:0]              tail_q, tail_d, head_q, head_d;
  logic [ROB_DEPTH-1:0]        alloc_q, alloc_d, done_q, done_d;
  logic [ROB_DEPTH*BANK_W-1:0] bank_id_q;
  logic [DATA_W-1:0]           data_q [ROB_DEPTH];

  logic [ROB_DEPTH-1:0]        wr_en;
  logic [ROB_DEPTH*DATA_W-1:0] wr_data;
  logic [ROB_W-1:0]            tail_idx, head_idx;
  logic                        kick_ok, retire, head_ready;

  xbar_rtn_demux #(
    .NUM_BANK (NUM_BANK),
    .ROB_DEPTH(ROB_DEPTH),
    .DATA_W   (DATA_W),
    .CH_ID_W  (CH_ID_W),
    .CH_ID    (CH_ID)
  ) u_demux (
    .bank_rtn_valid_i  (bank_rtn_valid_i),
    .bank_rtn_ch_id_i  (bank_rtn_ch_id_i),
    .bank_rtn_rob_num_i(bank_rtn_rob_num_i),
    .bank_rtn_data_i   (bank_rtn_data_i),
    .entry_alloc_i     (alloc_q),
    .entry_done_i      (done_q),
    .entry_bank_id_i   (bank_id_q),
    .wr_en_o           (wr_en),
    .wr_data_o         (wr_data)
  );

  assign tail_idx           = tail_q[ROB_W-1:0];
  assign head_idx           = head_q[ROB_W-1:0];
  assign rob_alloc_num_o    = tail_idx;
  assign rob_full_o         = (tail_idx == head_idx) && (tail_q[ROB_W] != head_q[ROB_W]);
  assign kick_ok            = req_kickoff_i && !rob_full_o;
  assign bank_rtn_allowIn_o = '1;
  assign head_ready         = alloc_q[head_idx] && done_q[head_idx];
  assign retire             = ch_rtn_data_valid_o && ch_rtn_data_ready_i;

`ifdef XBAR_ROB_BYPASS_EN
  logic head_bypass;
  assign head_bypass = alloc_q[head_idx] && !done_q[head_idx] && wr_en[head_idx];

  // Head is presented from storage when done, otherwise straight from the returning bank.
  always_comb begin
    ch_rtn_data_valid_o = head_ready || head_bypass;
    ch_rtn_data_o       = head_ready ? data_q[head_idx] : wr_data[head_idx*DATA_W +: DATA_W];
  end
`else
  // Head is presented only from registered storage.
  always_comb begin
    ch_rtn_data_valid_o = head_ready;
    ch_rtn_data_o       = data_q[head_idx];
  end
`endif

  // Next-state: returns set done, kickoff claims the tail, retire frees the head last so a
  // bypassed head never leaves a stale done bit behind.
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q | wr_en;
    tail_d  = tail_q;
    head_d  = head_q;
    if (kick_ok) begin
      alloc_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + 1'b1;
    end
    if (retire) begin
      alloc_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + 1'b1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tail_q  <= '0;
      head_q  <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      tail_q  <= tail_d;
      head_q  <= head_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is never reset; alloc/done qualify it.
  always_ff @(posedge clk_i) begin
    if (kick_ok) begin
      bank_id_q[tail_idx*BANK_W +: BANK_W] <= req_bank_id_i;
    end
    for (int e = 0; e < ROB_DEPTH; e++) begin
      if (wr_en[e]) begin
        data_q[e] <= wr_data[e*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_xbar_ch_rob.sv
// tb/tb_xbar_ch_rob.sv - directed scoreboard bench for xbar_ch_rob
module tb_xbar_ch_rob;

`ifdef XBAR_ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_kickoff_i;
  logic [1:0]   req_bank_id_i;
  logic [2:0]   rob_alloc_num_o;
  logic         rob_full_o;
  logic [3:0]   bank_rtn_valid_i;
  logic [3:0]   bank_rtn_allowIn_o;
  logic [7:0]   bank_rtn_ch_id_i;
  logic [11:0]  bank_rtn_rob_num_i;
  logic [511:0] bank_rtn_data_i;
  logic         ch_rtn_data_valid_o;
  logic         ch_rtn_data_ready_i;
  logic [127:0] ch_rtn_data_o;

  xbar_ch_rob dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_kickoff_i      (req_kickoff_i),
    .req_bank_id_i      (req_bank_id_i),
    .rob_alloc_num_o    (rob_alloc_num_o),
    .rob_full_o         (rob_full_o),
    .bank_rtn_valid_i   (bank_rtn_valid_i),
    .bank_rtn_allowIn_o (bank_rtn_allowIn_o),
    .bank_rtn_ch_id_i   (bank_rtn_ch_id_i),
    .bank_rtn_rob_num_i (bank_rtn_rob_num_i),
    .bank_rtn_data_i    (bank_rtn_data_i),
    .ch_rtn_data_valid_o(ch_rtn_data_valid_o),
    .ch_rtn_data_ready_i(ch_rtn_data_ready_i),
    .ch_rtn_data_o      (ch_rtn_data_o)
  );

  always #5 clk_i = ~clk_i;

  int           vectors = 0;
  int           fails   = 0;
  logic [127:0] exp_q [$];
  int           m_tail  = 0;
  int           m_bank [8];
  logic [127:0] m_data [8];
  logic [127:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input int i);
    return {4{32'(32'hC0DE0000 + i)}};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane(input int b, input int e, input logic [127:0] d, input int ch);
    bank_rtn_valid_i[b]            = 1'b1;
    bank_rtn_ch_id_i[b*2 +: 2]     = 2'(ch);
    bank_rtn_rob_num_i[b*3 +: 3]   = 3'(e);
    bank_rtn_data_i[b*128 +: 128]  = d;
  endtask

  task automatic clr_lanes();
    bank_rtn_valid_i = '0;
  endtask

  task automatic do_kick(input int bank, input logic [127:0] d);
    chk("alloc_num", 128'(rob_alloc_num_o), 128'(m_tail));
    req_kickoff_i  = 1'b1;
    req_bank_id_i  = 2'(bank);
    m_bank[m_tail] = bank;
    m_data[m_tail] = d;
    exp_q.push_back(d);
    m_tail = (m_tail + 1) % 8;
    cyc();
    req_kickoff_i = 1'b0;
  endtask

  task automatic ret_entry(input int e);
    set_lane(m_bank[e], e, m_data[e], 0);
    cyc();
    clr_lanes();
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain_pending", 128'(exp_q.size()), 128'(0));
  endtask

  // Scoreboard: every delivered beat must be the oldest outstanding kickoff's data.
  always @(negedge clk_i) begin
    if (!rst_i && ch_rtn_data_valid_o && ch_rtn_data_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 128'(1), 128'(0));
      else chk("ch_data", ch_rtn_data_o, exp_q.pop_front());
    end
  end

  initial begin
    rst_i = 1'b1; req_kickoff_i = 1'b0; req_bank_id_i = '0;
    bank_rtn_valid_i = '0; bank_rtn_ch_id_i = '0; bank_rtn_rob_num_i = '0;
    bank_rtn_data_i = '0; ch_rtn_data_ready_i = 1'b0;
    repeat (3) cyc();
    chk("rst_full", 128'(rob_full_o), 128'(0));
    chk("rst_valid", 128'(ch_rtn_data_valid_o), 128'(0));
    chk("rst_alloc", 128'(rob_alloc_num_o), 128'(0));
    rst_i = 1'b0;
    cyc();
    chk("allowin", 128'(bank_rtn_allowIn_o), 128'(4'hF));

    // Fill to full, kick while full, return in order, hold under backpressure, drain.
    for (int i = 0; i < 8; i++) do_kick(i % 4, dat(i));
    chk("full_after_8", 128'(rob_full_o), 128'(1));
    req_kickoff_i = 1'b1; req_bank_id_i = 2'd2;
    cyc();
    req_kickoff_i = 1'b0;
    chk("full_kick_tail", 128'(rob_alloc_num_o), 128'(0));
    chk("full_kick_full", 128'(rob_full_o), 128'(1));
    for (int e = 0; e < 8; e++) ret_entry(e);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 128'(ch_rtn_data_valid_o), 128'(1));
      chk("hold_data", ch_rtn_data_o, dat(0));
      cyc();
    end
    ch_rtn_data_ready_i = 1'b1;
    cyc();
    chk("full_after_retire", 128'(rob_full_o), 128'(0));
    wait_empty(20);
    chk("idle_valid", 128'(ch_rtn_data_valid_o), 128'(0));

    // Out of order: 2, 1, 0.
    for (int i = 0; i < 3; i++) do_kick(i + 1, dat(16 + i));
    ret_entry(2);
    chk("ooo_wait2", 128'(ch_rtn_data_valid_o), 128'(0));
    ret_entry(1);
    chk("ooo_wait1", 128'(ch_rtn_data_valid_o), 128'(0));
    ret_entry(0);
    for (int k = 0; k < (BYP ? 2 : 3); k++) begin
      chk("ooo_burst", 128'(ch_rtn_data_valid_o), 128'(1));
      cyc();
    end
    chk("ooo_end", 128'(ch_rtn_data_valid_o), 128'(0));
    wait_empty(10);

    // Four banks return in the same cycle.
    ch_rtn_data_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) do_kick(i, dat(32 + i));
    for (int b = 0; b < 4; b++) set_lane(b, 3 + b, dat(32 + b), 0);
    cyc();
    clr_lanes();
    chk("simul_head", ch_rtn_data_o, dat(32));
    ch_rtn_data_ready_i = 1'b1;
    wait_empty(10);

    // Foreign channel, wrong bank and unallocated returns are ignored.
    do_kick(1, dat(48));
    set_lane(1, 7, dat(99), 1); cyc(); clr_lanes();
    chk("foreign_ch", 128'(ch_rtn_data_valid_o), 128'(0));
    set_lane(2, 7, dat(98), 0); cyc(); clr_lanes();
    chk("wrong_bank", 128'(ch_rtn_data_valid_o), 128'(0));
    set_lane(0, 0, dat(97), 0); cyc(); clr_lanes();
    ret_entry(7);
    wait_empty(10);
    do_kick(0, dat(49));
    chk("unalloc_ignored", 128'(ch_rtn_data_valid_o), 128'(0));
    ret_entry(0);
    wait_empty(10);

    // Wrap through many alloc/retire rounds.
    for (int i = 0; i < 20; i++) begin
      do_kick(i % 4, dat(64 + i));
      ret_entry((m_tail + 7) % 8);
      wait_empty(10);
    end

    // Reset with three entries outstanding.
    ch_rtn_data_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_kick(i, dat(100 + i));
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
    m_tail = 0;
    chk("mid_rst_valid", 128'(ch_rtn_data_valid_o), 128'(0));
    chk("mid_rst_alloc", 128'(rob_alloc_num_o), 128'(0));
    chk("mid_rst_full", 128'(rob_full_o), 128'(0));
    set_lane(1, 1, dat(101), 0); cyc(); clr_lanes();
    chk("late_rtn_valid", 128'(ch_rtn_data_valid_o), 128'(0));
    do_kick(0, dat(110));
    do_kick(1, dat(111));
    ret_entry(1);
    chk("late_rtn_no_done", 128'(ch_rtn_data_valid_o), 128'(0));
    ch_rtn_data_ready_i = 1'b1;
    ret_entry(0);
    wait_empty(10);

    // Head return with ready high: bypass presents it in the same cycle.
    do_kick(2, dat(120));
    set_lane(2, 2, dat(120), 0);
    #2;
    chk("byp_same_cycle", 128'(ch_rtn_data_valid_o), 128'(BYP));
    if (BYP) chk("byp_data", ch_rtn_data_o, dat(120));
    cyc();
    clr_lanes();
    #1;
    chk("byp_next_cycle", 128'(ch_rtn_data_valid_o), 128'(!BYP));
    wait_empty(10);
    chk("byp_tail", 128'(rob_alloc_num_o), 128'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
